// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// ownership state encoding and default geometry/burst constants.
package mem_arb_pkg;

  localparam int DEF_AW        = 5;   // 32-word memory
  localparam int DEF_DW        = 16;  // 16-bit data words
  localparam int DEF_MAX_BURST = 8;   // accesses per ownership while the other side waits

  // Who currently owns the memory port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Width needed to count 0..max_burst inclusive.
  function automatic int bcnt_width(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding requesters plus the memory.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  // Requester 0
  logic          R0_REQ;
  logic          R0_LOCK;
  logic          R0_WEN;
  logic [AW-1:0] R0_ADDR;
  logic [DW-1:0] R0_DIN;
  logic          R0_GNT;
  logic          R0_RVALID;
  logic [DW-1:0] R0_RDATA;

  // Requester 1
  logic          R1_REQ;
  logic          R1_LOCK;
  logic          R1_WEN;
  logic [AW-1:0] R1_ADDR;
  logic [DW-1:0] R1_DIN;
  logic          R1_GNT;
  logic          R1_RVALID;
  logic [DW-1:0] R1_RDATA;

  // Memory port
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_DIN;
  logic          M_WEN;
  logic [DW-1:0] M_DOUT;

  modport slave (
    input  R0_REQ, R0_LOCK, R0_WEN, R0_ADDR, R0_DIN,
    input  R1_REQ, R1_LOCK, R1_WEN, R1_ADDR, R1_DIN,
    input  M_DOUT,
    output R0_GNT, R0_RVALID, R0_RDATA,
    output R1_GNT, R1_RVALID, R1_RDATA,
    output M_ADDR, M_DIN, M_WEN
  );

  modport master (
    output R0_REQ, R0_LOCK, R0_WEN, R0_ADDR, R0_DIN,
    output R1_REQ, R1_LOCK, R1_WEN, R1_ADDR, R1_DIN,
    output M_DOUT,
    input  R0_GNT, R0_RVALID, R0_RDATA,
    input  R1_GNT, R1_RVALID, R1_RDATA,
    input  M_ADDR, M_DIN, M_WEN
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one port of a dual-port memory.
// Ownership is granted round-robin from IDLE with one cycle of arbitration
// latency, then held while the owner keeps requesting, until MAX_BURST
// accesses have been made with the other side waiting, or indefinitely while
// the owner asserts LOCK. Grants and the memory-port mux are combinational
// from the owner's request; read-valid is a one-cycle delayed flag that lines
// up with the memory's registered read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              CLK,
  input  logic              RESET,
  mem_port_arbiter_if.slave bus
);

  localparam int            BW       = bcnt_width(MAX_BURST);
  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);

  arb_state_e    state_r;
  arb_state_e    state_nxt_s;
  logic          last_r;        // last owner; 1 after reset so R0 wins the first tie
  logic          last_nxt_s;
  logic [BW-1:0] bcnt_r;
  logic [BW-1:0] bcnt_inc_s;
  logic [BW-1:0] bcnt_nxt_s;
  logic          rd_pend0_r;
  logic          rd_pend1_r;

  logic          own_req_s;
  logic          own_lock_s;
  logic          other_req_s;
  logic          leave_s;

  logic          gnt0_s;
  logic          gnt1_s;
  logic          wen_s;
  logic          rd_acc0_s;
  logic          rd_acc1_s;
  logic [AW-1:0] addr_mux_s;
  logic [DW-1:0] din_mux_s;

  // Pick the owner's view of the request lines and decide whether this
  // cycle ends its ownership. The count includes this cycle's access so the
  // access that reaches MAX_BURST is the last one granted.
  always_comb begin
    own_req_s   = 1'b0;
    own_lock_s  = 1'b0;
    other_req_s = 1'b0;
    case (state_r)
      OWN0: begin
        own_req_s   = bus.R0_REQ;
        own_lock_s  = bus.R0_LOCK;
        other_req_s = bus.R1_REQ;
      end
      OWN1: begin
        own_req_s   = bus.R1_REQ;
        own_lock_s  = bus.R1_LOCK;
        other_req_s = bus.R0_REQ;
      end
      default: begin
        own_req_s   = 1'b0;
        own_lock_s  = 1'b0;
        other_req_s = 1'b0;
      end
    endcase

    if (own_req_s && (bcnt_r != BCNT_MAX)) begin
      bcnt_inc_s = bcnt_r + BCNT_ONE;
    end else begin
      bcnt_inc_s = bcnt_r;
    end

    leave_s = !own_lock_s &&
              (!own_req_s || ((bcnt_inc_s == BCNT_MAX) && other_req_s));
  end

  // Next ownership state, round-robin pointer and burst count.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (bus.R0_REQ && bus.R1_REQ) begin
          state_nxt_s = last_r ? OWN0 : OWN1;
        end else if (bus.R0_REQ) begin
          state_nxt_s = OWN0;
        end else if (bus.R1_REQ) begin
          state_nxt_s = OWN1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN0: begin
        if (leave_s) begin
          last_nxt_s  = 1'b0;
          state_nxt_s = bus.R1_REQ ? OWN1 : IDLE;
        end else begin
          state_nxt_s = OWN0;
        end
      end
      OWN1: begin
        if (leave_s) begin
          last_nxt_s  = 1'b1;
          state_nxt_s = bus.R0_REQ ? OWN0 : IDLE;
        end else begin
          state_nxt_s = OWN1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (state_nxt_s != state_r) begin
      bcnt_nxt_s = '0;
    end else begin
      bcnt_nxt_s = bcnt_inc_s;
    end
  end

  // Grants and memory-port mux; everything is zero outside ownership, which
  // also covers the reset case because reset forces IDLE immediately.
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    wen_s      = 1'b0;
    rd_acc0_s  = 1'b0;
    rd_acc1_s  = 1'b0;
    addr_mux_s = '0;
    din_mux_s  = '0;
    case (state_r)
      OWN0: begin
        gnt0_s     = bus.R0_REQ;
        wen_s      = bus.R0_REQ & bus.R0_WEN;
        rd_acc0_s  = bus.R0_REQ & ~bus.R0_WEN;
        addr_mux_s = bus.R0_ADDR;
        din_mux_s  = bus.R0_DIN;
      end
      OWN1: begin
        gnt1_s     = bus.R1_REQ;
        wen_s      = bus.R1_REQ & bus.R1_WEN;
        rd_acc1_s  = bus.R1_REQ & ~bus.R1_WEN;
        addr_mux_s = bus.R1_ADDR;
        din_mux_s  = bus.R1_DIN;
      end
      default: begin
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        wen_s      = 1'b0;
        rd_acc0_s  = 1'b0;
        rd_acc1_s  = 1'b0;
        addr_mux_s = '0;
        din_mux_s  = '0;
      end
    endcase
  end

  // Drive the interface outputs; read data is passed straight through and
  // qualified only by the read-valid flags.
  always_comb begin
    bus.R0_GNT    = gnt0_s;
    bus.R1_GNT    = gnt1_s;
    bus.M_WEN     = wen_s;
    bus.M_ADDR    = addr_mux_s;
    bus.M_DIN     = din_mux_s;
    bus.R0_RVALID = rd_pend0_r;
    bus.R1_RVALID = rd_pend1_r;
    bus.R0_RDATA  = bus.M_DOUT;
    bus.R1_RDATA  = bus.M_DOUT;
  end

  // Ownership state, round-robin pointer and burst counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      bcnt_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
    end
  end

  // Pending-read flags: one cycle after an accepted read the memory output
  // holds that read's data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_pend0_r <= 1'b0;
      rd_pend1_r <= 1'b0;
    end else begin
      rd_pend0_r <= rd_acc0_s;
      rd_pend1_r <= rd_acc1_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a behavioural
// 32x16 synchronous memory on the arbitrated port.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(5), .DW(16)) bus ();

  mem_port_arbiter #(.AW(5), .DW(16), .MAX_BURST(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  // Memory port: write at the clock edge, registered read of the old contents.
  logic [15:0] mem [32];
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
    end else begin
      if (bus.M_WEN) mem[bus.M_ADDR] <= bus.M_DIN;
    end
    bus.M_DOUT <= mem[bus.M_ADDR];
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic req, input logic lock, input logic wen,
                       input logic [4:0] addr, input logic [15:0] din);
    if (n == 0) begin
      bus.R0_REQ = req; bus.R0_LOCK = lock; bus.R0_WEN = wen;
      bus.R0_ADDR = addr; bus.R0_DIN = din;
    end else begin
      bus.R1_REQ = req; bus.R1_LOCK = lock; bus.R1_WEN = wen;
      bus.R1_ADDR = addr; bus.R1_DIN = din;
    end
  endtask

  // Stress bookkeeping
  logic        op_v   [2];
  logic        op_wen [2];
  logic [4:0]  op_addr[2];
  logic [15:0] op_din [2];
  logic        exp_v  [2];
  logic [15:0] exp_d  [2];
  logic        nxt_v  [2];
  logic [15:0] nxt_d  [2];
  int          wait_c [2];
  logic        g      [2];
  logic        rv     [2];
  logic [15:0] rd     [2];

  initial begin
    int i0;
    int g0cnt;
    int max_wait;
    int issued;
    int granted;
    logic r1_got;

    for (int i = 0; i < 32; i++) sb[i] = 16'h0000;
    mem_clr = 1'b1;
    rst     = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b1, 5'd7, 16'hFFFF);
    drive(1, 1'b1, 1'b0, 1'b1, 5'd9, 16'hEEEE);
    #2;
    // ---- reset state: requests present, nothing may leak out
    check("rst_gnt0",   bus.R0_GNT, 32'd0);
    check("rst_gnt1",   bus.R1_GNT, 32'd0);
    check("rst_mwen",   bus.M_WEN, 32'd0);
    check("rst_maddr",  bus.M_ADDR, 32'd0);
    check("rst_mdin",   bus.M_DIN, 32'd0);
    check("rst_rv0",    bus.R0_RVALID, 32'd0);
    check("rst_rv1",    bus.R1_RVALID, 32'd0);
    check("rst_state",  32'(dut.state_r), 32'(IDLE));
    cyc();
    cyc();
    mem_clr = 1'b0;
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    cyc();

    // ---- A: R0 write addr 3 = A5A5, then read it back
    drive(0, 1'b1, 1'b0, 1'b1, 5'd3, 16'hA5A5);
    #1;
    check("a_c1_gnt0", bus.R0_GNT, 32'd0);
    check("a_c1_mwen", bus.M_WEN, 32'd0);
    cyc();
    #1;
    check("a_c2_gnt0",  bus.R0_GNT, 32'd1);
    check("a_c2_gnt1",  bus.R1_GNT, 32'd0);
    check("a_c2_mwen",  bus.M_WEN, 32'd1);
    check("a_c2_maddr", bus.M_ADDR, 32'd3);
    check("a_c2_mdin",  bus.M_DIN, 32'hA5A5);
    sb[3] = 16'hA5A5;
    cyc();
    drive(0, 1'b1, 1'b0, 1'b0, 5'd3, 16'h0);
    #1;
    check("a_c3_gnt0", bus.R0_GNT, 32'd1);
    check("a_c3_mwen", bus.M_WEN, 32'd0);
    check("a_wr_no_rv", bus.R0_RVALID, 32'd0);
    cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("a_rd_rv0",  bus.R0_RVALID, 32'd1);
    check("a_rd_data", bus.R0_RDATA, 32'hA5A5);
    check("a_c4_gnt0", bus.R0_GNT, 32'd0);
    cyc();
    #1;
    check("a_rv_single", bus.R0_RVALID, 32'd0);
    check("a_idle",      32'(dut.state_r), 32'(IDLE));

    // ---- B: simultaneous requests from reset: R0 first, R1 follows with no gap
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    drive(0, 1'b1, 1'b0, 1'b0, 5'd3, 16'h0);
    drive(1, 1'b1, 1'b0, 1'b1, 5'd5, 16'h1234);
    #1;
    check("b_c1_gnt0", bus.R0_GNT, 32'd0);
    check("b_c1_gnt1", bus.R1_GNT, 32'd0);
    cyc();
    #1;
    check("b_c2_gnt0",  bus.R0_GNT, 32'd1);
    check("b_c2_gnt1",  bus.R1_GNT, 32'd0);
    check("b_c2_maddr", bus.M_ADDR, 32'd3);
    cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("b_c3_gnt0", bus.R0_GNT, 32'd0);
    check("b_c3_gnt1", bus.R1_GNT, 32'd0);
    check("b_c3_rv0",  bus.R0_RVALID, 32'd1);
    check("b_c3_rd0",  bus.R0_RDATA, 32'hA5A5);
    cyc();
    #1;
    check("b_c4_gnt1", bus.R1_GNT, 32'd1);
    check("b_c4_mwen", bus.M_WEN, 32'd1);
    check("b_c4_mdin", bus.M_DIN, 32'h1234);
    check("b_c4_rv0",  bus.R0_RVALID, 32'd0);
    sb[5] = 16'h1234;
    cyc();
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("b_wr_no_rv1", bus.R1_RVALID, 32'd0);
    cyc();

    // ---- C: R0 streams 20 writes while R1 waits for one read of addr 3
    i0 = 0;
    g0cnt = 0;
    r1_got = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b1, 5'd8, 16'hC000);
    drive(1, 1'b1, 1'b0, 1'b0, 5'd3, 16'h0);
    #1;
    check("c_arb_gnt0", bus.R0_GNT, 32'd0);
    for (int k = 0; k < 40 && !r1_got; k++) begin
      cyc();
      drive(0, 1'b1, 1'b0, 1'b1, 5'(8 + i0), 16'(16'hC000 + i0));
      #1;
      check("c_excl", 32'(bus.R0_GNT & bus.R1_GNT), 32'd0);
      if (bus.R0_GNT) begin
        sb[8 + i0] = 16'(16'hC000 + i0);
        g0cnt++;
        i0++;
      end
      if (bus.R1_GNT) r1_got = 1'b1;
    end
    check("c_r0_burst",   32'(g0cnt), 32'd8);
    check("c_r1_granted", 32'(r1_got), 32'd1);
    check("c_r1_maddr",   bus.M_ADDR, 32'd3);
    cyc();
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    drive(0, 1'b1, 1'b0, 1'b1, 5'(8 + i0), 16'(16'hC000 + i0));
    #1;
    check("c_r1_rv",   bus.R1_RVALID, 32'd1);
    check("c_r1_data", bus.R1_RDATA, 32'hA5A5);
    check("c_hand_gnt0", bus.R0_GNT, 32'd0);
    for (int k = 0; k < 30 && i0 < 20; k++) begin
      cyc();
      drive(0, 1'b1, 1'b0, 1'b1, 5'(8 + i0), 16'(16'hC000 + i0));
      #1;
      if (k == 0) check("c_r0_regain", bus.R0_GNT, 32'd1);
      if (bus.R0_GNT) begin
        sb[8 + i0] = 16'(16'hC000 + i0);
        i0++;
      end
    end
    check("c_r0_total", 32'(i0), 32'd20);
    cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    cyc();

    // ---- D: R1 locked with REQ 1,0,0,1 while R0 waits
    drive(1, 1'b1, 1'b1, 1'b0, 5'd30, 16'h0);
    #1;
    check("d_arb_gnt1", bus.R1_GNT, 32'd0);
    cyc();
    drive(0, 1'b1, 1'b0, 1'b0, 5'd8, 16'h0);
    #1;
    check("d_p0_gnt1", bus.R1_GNT, 32'd1);
    check("d_p0_gnt0", bus.R0_GNT, 32'd0);
    cyc();
    drive(1, 1'b0, 1'b1, 1'b0, 5'd30, 16'h0);
    #1;
    check("d_p1_gnt0", bus.R0_GNT, 32'd0);
    check("d_p1_gnt1", bus.R1_GNT, 32'd0);
    check("d_p1_rv1",  bus.R1_RVALID, 32'd1);
    check("d_p1_rd1",  bus.R1_RDATA, 32'(sb[30]));
    cyc();
    #1;
    check("d_p2_gnt0", bus.R0_GNT, 32'd0);
    check("d_p2_rv1",  bus.R1_RVALID, 32'd0);
    cyc();
    drive(1, 1'b1, 1'b1, 1'b1, 5'd30, 16'hBEEF);
    #1;
    check("d_p3_gnt1", bus.R1_GNT, 32'd1);
    check("d_p3_gnt0", bus.R0_GNT, 32'd0);
    check("d_p3_mwen", bus.M_WEN, 32'd1);
    check("d_p3_mdin", bus.M_DIN, 32'hBEEF);
    sb[30] = 16'hBEEF;
    cyc();
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("d_p4_gnt0", bus.R0_GNT, 32'd0);
    check("d_p4_rv1",  bus.R1_RVALID, 32'd0);
    cyc();
    #1;
    check("d_p5_gnt0",  bus.R0_GNT, 32'd1);
    check("d_p5_maddr", bus.M_ADDR, 32'd8);
    cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("d_p6_rv0", bus.R0_RVALID, 32'd1);
    check("d_p6_rd0", bus.R0_RDATA, 32'(sb[8]));
    cyc();

    // ---- E: reset right after an R1 read is accepted
    drive(1, 1'b1, 1'b0, 1'b0, 5'd30, 16'h0);
    cyc();
    #1;
    check("e_gnt1", bus.R1_GNT, 32'd1);
    cyc();
    rst = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b1, 5'd30, 16'hDEAD);
    #1;
    check("e_rst_rv1",   bus.R1_RVALID, 32'd0);
    check("e_rst_mwen",  bus.M_WEN, 32'd0);
    check("e_rst_gnt1",  bus.R1_GNT, 32'd0);
    check("e_rst_maddr", bus.M_ADDR, 32'd0);
    check("e_rst_state", 32'(dut.state_r), 32'(IDLE));
    cyc();
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    #1;
    check("e_post_rv1",   bus.R1_RVALID, 32'd0);
    check("e_post_state", 32'(dut.state_r), 32'(IDLE));
    cyc();

    // ---- F: random two-requester stress against the scoreboard
    max_wait = 0;
    issued = 0;
    granted = 0;
    for (int n = 0; n < 2; n++) begin
      op_v[n] = 1'b0; op_wen[n] = 1'b0; op_addr[n] = 5'd0; op_din[n] = 16'h0;
      exp_v[n] = 1'b0; exp_d[n] = 16'h0; wait_c[n] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!op_v[n] && (c < 380) && ($urandom_range(0, 2) != 0)) begin
          op_v[n]    = 1'b1;
          op_wen[n]  = 1'($urandom_range(0, 1));
          op_addr[n] = 5'($urandom_range(0, 31));
          op_din[n]  = 16'($urandom);
          wait_c[n]  = 0;
          issued++;
        end
        drive(n, op_v[n], 1'b0, op_wen[n], op_addr[n], op_din[n]);
      end
      #1;
      g[0] = bus.R0_GNT;    g[1] = bus.R1_GNT;
      rv[0] = bus.R0_RVALID; rv[1] = bus.R1_RVALID;
      rd[0] = bus.R0_RDATA;  rd[1] = bus.R1_RDATA;
      check("f_excl", 32'(g[0] & g[1]), 32'd0);
      if (!g[0] && !g[1]) check("f_idle_mwen", bus.M_WEN, 32'd0);
      for (int n = 0; n < 2; n++) begin
        check("f_rvalid", 32'(rv[n]), 32'(exp_v[n]));
        if (exp_v[n]) check("f_rdata", 32'(rd[n]), 32'(exp_d[n]));
        nxt_v[n] = 1'b0;
        nxt_d[n] = 16'h0;
        if (g[n]) begin
          check("f_gnt_req", 32'(op_v[n]), 32'd1);
          check("f_maddr", bus.M_ADDR, 32'(op_addr[n]));
          check("f_mwen",  bus.M_WEN, 32'(op_wen[n]));
          if (op_wen[n]) begin
            check("f_mdin", bus.M_DIN, 32'(op_din[n]));
            sb[op_addr[n]] = op_din[n];
          end else begin
            nxt_v[n] = 1'b1;
            nxt_d[n] = sb[op_addr[n]];
          end
          op_v[n] = 1'b0;
          granted++;
        end else if (op_v[n]) begin
          wait_c[n]++;
          if (wait_c[n] > max_wait) max_wait = wait_c[n];
        end
      end
      for (int n = 0; n < 2; n++) begin
        exp_v[n] = nxt_v[n];
        exp_d[n] = nxt_d[n];
      end
      cyc();
    end
    check("f_no_lost",  32'(granted), 32'(issued));
    check("f_drained",  32'(op_v[0] | op_v[1]), 32'd0);
    check("f_max_wait", 32'(max_wait <= 24), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
